// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared state encodings and constants for the FIFO read path
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

  localparam int FIFO_WIDTH = 8;
  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - FIFO read port plus downstream valid/ready stream
interface fifo_stream_reader_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
);

  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_r_en;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_r_en, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_r_en, m_valid, m_data, m_last
  );

endinterface

// File: rtl/fifo_skid_buf.sv
// rtl/fifo_skid_buf.sv - two-entry shift buffer absorbing the FIFO read latency
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic [1:0]       occ_after_pop;

  assign occ_after_pop = occ - {1'b0, pop};
  assign head_data     = slot0;

  // Shift happens first; a same-cycle push lands in the first slot left free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      occ   <= '0;
    end else begin
      if (pop) begin
        slot0 <= slot1;
      end
      if (push) begin
        if (occ_after_pop == 2'd0) begin
          slot0 <= push_data;
        end else begin
          slot1 <= push_data;
        end
      end
      occ <= occ_after_pop + {1'b0, push};
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - pops the FIFO and emits a packetised valid/ready stream
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH,
  parameter int BURST_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  output logic                 busy,
  fifo_stream_reader_if.master bus
);

  localparam int                CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BURST_LEN - 1);

  rd_state_t        state;
  rd_state_t        state_next;
  logic             inflight;
  logic [CNT_W-1:0] beat_cnt;
  logic [1:0]       occ;
  logic [WIDTH-1:0] head_data;
  logic             pop_out;
  logic             pop_req;
  logic [2:0]       pending;

  fifo_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (bus.fifo_data),
    .pop       (pop_out),
    .head_data (head_data),
    .occ       (occ)
  );

  assign pop_out = bus.m_valid & bus.m_ready;

  // Words that will sit in the buffer next cycle; a new pop must still fit.
  assign pending = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop_out};
  assign pop_req = rst_n & (state == ST_RUN) & ~bus.fifo_empty
                 & (pending < 3'(SKID_DEPTH));

  assign bus.fifo_r_en = pop_req;
  assign bus.m_valid   = (occ != 2'd0);
  assign bus.m_data    = head_data;
  assign bus.m_last    = bus.m_valid & (beat_cnt == LAST_CNT);
  assign busy          = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (enable) state_next = ST_RUN;
      ST_RUN:   if (!enable) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (enable) begin
          state_next = ST_RUN;
        end else if ((occ == 2'd0) && !inflight) begin
          state_next = ST_IDLE;
        end
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  // beat_cnt survives DRAIN/IDLE so an interrupted packet resumes mid-burst.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      beat_cnt <= '0;
    end else begin
      inflight <= pop_req;
      if (pop_out) begin
        if (beat_cnt == LAST_CNT) begin
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;

  logic clk;
  logic rst_n;
  logic enable;
  logic busy;

  fifo_stream_reader_if #(.WIDTH(8)) ifc ();

  fifo_stream_reader #(.WIDTH(8), .BURST_LEN(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .busy   (busy),
    .bus    (ifc)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [0:255];
  int wr_ptr   = 0;
  int rd_ptr   = 0;
  int bad_pops = 0;

  logic [7:0] bd [0:63];
  logic       bl [0:63];
  int nb = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: registered read data one cycle after a pop.
  assign ifc.fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (ifc.fifo_r_en && (wr_ptr != rd_ptr)) begin
      ifc.fifo_data <= mem[rd_ptr & 255];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && ifc.m_valid && ifc.m_ready) begin
      bd[nb & 63] <= ifc.m_data;
      bl[nb & 63] <= ifc.m_last;
      nb          <= nb + 1;
    end
    if (ifc.fifo_r_en && ifc.fifo_empty) begin
      bad_pops <= bad_pops + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    mem[wr_ptr & 255] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    enable      = 1'b0;
    ifc.m_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int k = 0;
    while (nb < n && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(nb >= n), 32'd1);
  endtask

  task automatic chk_seq(input string tag, input int base, input int n,
                         input logic [7:0] first, input int last_idx);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"}, {24'd0, bd[(base + i) & 63]}, {24'd0, 8'(first + 8'(i))});
      chk({tag, "_last"}, {31'd0, bl[(base + i) & 63]}, 32'(i == last_idx));
    end
  endtask

  initial begin
    int base;
    rst_n       = 1'b0;
    enable      = 1'b0;
    ifc.m_ready = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_m_valid", {31'd0, ifc.m_valid}, 32'd0);
    chk("rst_m_data", {24'd0, ifc.m_data}, 32'd0);
    chk("rst_m_last", {31'd0, ifc.m_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_r_en", {31'd0, ifc.fifo_r_en}, 32'd0);

    // Basic stream: 3-cycle first-beat latency, one beat per cycle
    do_reset();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    enable      = 1'b1;
    ifc.m_ready = 1'b1;
    settle();
    chk("t1_c0_r_en", {31'd0, ifc.fifo_r_en}, 32'd0);
    step();
    chk("t1_c1_r_en", {31'd0, ifc.fifo_r_en}, 32'd1);
    chk("t1_c1_valid", {31'd0, ifc.m_valid}, 32'd0);
    step();
    chk("t1_c2_valid", {31'd0, ifc.m_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_valid", {31'd0, ifc.m_valid}, 32'd1);
      chk("t1_data", {24'd0, ifc.m_data}, {24'd0, 8'(8'h11 * (i + 1))});
      chk("t1_last", {31'd0, ifc.m_last}, 32'(i == 3));
    end
    step();
    chk("t1_c7_valid", {31'd0, ifc.m_valid}, 32'd0);
    chk("t1_c7_r_en", {31'd0, ifc.fifo_r_en}, 32'd0);
    enable = 1'b0;
    step();
    step();
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);

    // Backpressure: m_ready low for cycles 4..9
    do_reset();
    for (int i = 0; i < 6; i++) push(8'hA1 + 8'(i));
    enable      = 1'b1;
    ifc.m_ready = 1'b1;
    base        = nb;
    step();
    step();
    step();
    chk("t2_c3_data", {24'd0, ifc.m_data}, 32'hA1);
    step();
    ifc.m_ready = 1'b0;
    settle();
    chk("t2_c4_r_en", {31'd0, ifc.fifo_r_en}, 32'd0);
    for (int c = 5; c <= 9; c++) begin
      step();
      chk("t2_hold_valid", {31'd0, ifc.m_valid}, 32'd1);
      chk("t2_hold_data", {24'd0, ifc.m_data}, 32'hA2);
      chk("t2_hold_r_en", {31'd0, ifc.fifo_r_en}, 32'd0);
    end
    step();
    ifc.m_ready = 1'b1;
    settle();
    chk("t2_c10_r_en", {31'd0, ifc.fifo_r_en}, 32'd1);
    wait_beats(base + 6, 20, "t2_wait");
    step();
    chk("t2_count", 32'(nb - base), 32'd6);
    chk_seq("t2", base, 6, 8'hA1, 3);
    enable = 1'b0;
    repeat (4) step();

    // Empty stall: 2 words, then 3 more after the buffer runs dry
    do_reset();
    push(8'h01); push(8'h02);
    enable      = 1'b1;
    ifc.m_ready = 1'b1;
    base        = nb;
    step();
    chk("t3_c1_r_en", {31'd0, ifc.fifo_r_en}, 32'd1);
    step();
    chk("t3_c2_r_en", {31'd0, ifc.fifo_r_en}, 32'd1);
    step();
    chk("t3_c3_r_en", {31'd0, ifc.fifo_r_en}, 32'd0);
    chk("t3_c3_data", {24'd0, ifc.m_data}, 32'h01);
    step();
    chk("t3_c4_data", {24'd0, ifc.m_data}, 32'h02);
    step();
    chk("t3_c5_valid", {31'd0, ifc.m_valid}, 32'd0);
    step();
    chk("t3_c6_valid", {31'd0, ifc.m_valid}, 32'd0);
    push(8'h03); push(8'h04); push(8'h05);
    settle();
    chk("t3_c6_r_en", {31'd0, ifc.fifo_r_en}, 32'd1);
    wait_beats(base + 5, 20, "t3_wait");
    chk_seq("t3", base, 5, 8'h01, 3);
    enable = 1'b0;
    repeat (4) step();

    // Drain: enable dropped with one word buffered and one in flight
    do_reset();
    for (int i = 0; i < 6; i++) push(8'h31 + 8'(i));
    enable      = 1'b1;
    ifc.m_ready = 1'b1;
    base        = nb;
    repeat (4) step();
    chk("t4_c4_data", {24'd0, ifc.m_data}, 32'h32);
    enable = 1'b0;
    settle();
    chk("t4_c4_r_en", {31'd0, ifc.fifo_r_en}, 32'd1);
    step();
    chk("t4_c5_busy", {31'd0, busy}, 32'd1);
    chk("t4_c5_r_en", {31'd0, ifc.fifo_r_en}, 32'd0);
    chk("t4_c5_data", {24'd0, ifc.m_data}, 32'h33);
    step();
    chk("t4_c6_r_en", {31'd0, ifc.fifo_r_en}, 32'd0);
    chk("t4_c6_data", {24'd0, ifc.m_data}, 32'h34);
    chk("t4_c6_last", {31'd0, ifc.m_last}, 32'd1);
    step();
    chk("t4_c7_valid", {31'd0, ifc.m_valid}, 32'd0);
    chk("t4_c7_r_en", {31'd0, ifc.fifo_r_en}, 32'd0);
    step();
    chk("t4_c8_busy", {31'd0, busy}, 32'd0);
    chk("t4_count", 32'(nb - base), 32'd4);

    // Mid-packet resume: 2 beats, back to IDLE, 2 more closes the packet
    enable = 1'b1;
    base   = nb;
    wait_beats(base + 2, 20, "t5_wait_a");
    chk_seq("t5a", base, 2, 8'h35, -1);
    enable = 1'b0;
    repeat (4) step();
    chk("t5_idle_busy", {31'd0, busy}, 32'd0);
    push(8'h41); push(8'h42);
    enable = 1'b1;
    base   = nb;
    wait_beats(base + 2, 20, "t5_wait_b");
    chk_seq("t5b", base, 2, 8'h41, 1);

    // Reset mid-stream with two words buffered and beat_cnt at 1
    do_reset();
    for (int i = 0; i < 6; i++) push(8'h51 + 8'(i));
    enable      = 1'b1;
    ifc.m_ready = 1'b1;
    repeat (4) step();
    ifc.m_ready = 1'b0;
    step();
    chk("t6_c5_valid", {31'd0, ifc.m_valid}, 32'd1);
    chk("t6_c5_data", {24'd0, ifc.m_data}, 32'h52);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    settle();
    chk("t6_valid", {31'd0, ifc.m_valid}, 32'd0);
    chk("t6_data", {24'd0, ifc.m_data}, 32'd0);
    chk("t6_last", {31'd0, ifc.m_last}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_r_en", {31'd0, ifc.fifo_r_en}, 32'd0);
    push(8'h57);
    ifc.m_ready = 1'b1;
    base        = nb;
    step();
    step();
    step();
    chk("t6_resume_valid", {31'd0, ifc.m_valid}, 32'd1);
    chk("t6_resume_data", {24'd0, ifc.m_data}, 32'h54);
    wait_beats(base + 4, 20, "t6_wait");
    chk_seq("t6", base, 4, 8'h54, 3);

    chk("no_pop_when_empty", 32'(bad_pops), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
